// File: rtl/util_axis_framer_pkg.sv
// ============================================================================
// Module      : util_axis_framer_pkg
// Description : Shared AXI-Stream defaults and sizing helpers for util_ blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package util_axis_framer_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int BEAT_CNT_WIDTH  = 16;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/util_axis_skid.sv
// ============================================================================
// Module      : util_axis_skid
// Description : 2-entry registered skid buffer; head entry drives the output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module util_axis_skid #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full_nxt
);

  logic             r_vld0;
  logic             r_vld1;
  logic [WIDTH-1:0] r_d0;
  logic [WIDTH-1:0] r_d1;
  logic             w_pop;

  assign w_pop = r_vld0 & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      r_d0   <= '0;
      r_d1   <= '0;
    end else if (w_pop) begin
      if (r_vld1) begin
        r_d0   <= r_d1;
        r_vld1 <= i_push;
        if (i_push) r_d1 <= i_data;
      end else begin
        r_vld0 <= i_push;
        if (i_push) r_d0 <= i_data;
      end
    end else if (i_push) begin
      if (!r_vld0) begin
        r_d0   <= i_data;
        r_vld0 <= 1'b1;
      end else begin
        r_d1   <= i_data;
        r_vld1 <= 1'b1;
      end
    end
  end

  // Occupancy after this edge is 2; lets the owner register its ready from it.
  assign o_full_nxt = r_vld1 ? (!w_pop || i_push) : (r_vld0 && i_push && !w_pop);
  assign o_valid    = r_vld0;
  assign o_data     = r_d0;

endmodule

`default_nettype wire

// File: rtl/util_axis_framer.sv
// ============================================================================
// Module      : util_axis_framer
// Description : Cuts a continuous AXI-Stream into fixed-length tlast frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module util_axis_framer
  import util_axis_framer_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int FRAME_LEN  = 256,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic                  m_axis_data_tlast,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int GW       = cnt_width(GAP_CYCLES);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t                    r_state, w_state_nxt;
  logic [BEAT_CNT_WIDTH-1:0] r_beat,  w_beat_nxt;
  logic [GW-1:0]             r_gap,   w_gap_nxt;
  logic                      r_s_tready;
  logic [CNT_WIDTH-1:0]      r_frame_count;
  logic                      w_push;
  logic                      w_tag_last;
  logic                      w_full_nxt;
  logic                      w_m_valid;
  logic [DATA_WIDTH:0]       w_m_beat;

  assign w_push     = s_axis_data_tvalid & r_s_tready;
  assign w_tag_last = (r_beat == BEAT_CNT_WIDTH'(FRAME_LEN - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_gap_nxt   = r_gap;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_RUN;
          w_beat_nxt  = '0;
        end
      end
      ST_RUN: begin
        if (w_push) begin
          if (w_tag_last) begin
            w_beat_nxt = '0;
            if (GAP_CYCLES > 0) begin
              w_state_nxt = ST_GAP;
              w_gap_nxt   = '0;
            end else if (!enable) begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (r_gap == GW'(GAP_LAST)) begin
          w_gap_nxt   = '0;
          w_state_nxt = enable ? ST_RUN : ST_IDLE;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_beat        <= '0;
      r_gap         <= '0;
      r_s_tready    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat     <= w_beat_nxt;
      r_gap      <= w_gap_nxt;
      // Ready looks ahead one edge so the skid is never pushed while full.
      r_s_tready <= (w_state_nxt == ST_RUN) && !w_full_nxt;
      if (w_m_valid && m_axis_data_tready && w_m_beat[DATA_WIDTH])
        r_frame_count <= r_frame_count + 1'b1;
    end
  end

  util_axis_skid #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk        (aclk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_data     ({w_tag_last, s_axis_data_tdata}),
    .i_ready    (m_axis_data_tready),
    .o_valid    (w_m_valid),
    .o_data     (w_m_beat),
    .o_full_nxt (w_full_nxt)
  );

  assign s_axis_data_tready = r_s_tready;
  assign m_axis_data_tvalid = w_m_valid;
  assign m_axis_data_tdata  = w_m_beat[DATA_WIDTH-1:0];
  assign m_axis_data_tlast  = w_m_beat[DATA_WIDTH];
  assign frame_count        = r_frame_count;
  assign busy               = (r_state != ST_IDLE) || w_m_valid;

endmodule

`default_nettype wire

// File: tb/tb_util_axis_framer.sv
// ============================================================================
// Module      : tb_util_axis_framer
// Description : Self-checking bench; counting source feeds three framer configs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_util_axis_framer;

  localparam int DW = 32;

  logic aclk = 1'b0;
  logic rst_n = 1'b0;
  logic enable  [3];
  logic s_valid [3];
  logic s_ready [3];
  logic m_valid [3];
  logic m_ready [3];
  logic m_last  [3];
  logic busy    [3];
  logic [DW-1:0] s_data [3];
  logic [DW-1:0] m_data [3];
  logic [15:0] fc_a, fc_b;
  logic [1:0]  fc_c;

  always #5 aclk = ~aclk;

  util_axis_framer #(.DATA_WIDTH(DW), .FRAME_LEN(4), .GAP_CYCLES(0), .CNT_WIDTH(16)) u_a (
    .aclk(aclk), .rst_n(rst_n), .enable(enable[0]),
    .s_axis_data_tvalid(s_valid[0]), .s_axis_data_tready(s_ready[0]), .s_axis_data_tdata(s_data[0]),
    .m_axis_data_tvalid(m_valid[0]), .m_axis_data_tready(m_ready[0]), .m_axis_data_tdata(m_data[0]),
    .m_axis_data_tlast(m_last[0]), .frame_count(fc_a), .busy(busy[0]));

  util_axis_framer #(.DATA_WIDTH(DW), .FRAME_LEN(4), .GAP_CYCLES(2), .CNT_WIDTH(16)) u_b (
    .aclk(aclk), .rst_n(rst_n), .enable(enable[1]),
    .s_axis_data_tvalid(s_valid[1]), .s_axis_data_tready(s_ready[1]), .s_axis_data_tdata(s_data[1]),
    .m_axis_data_tvalid(m_valid[1]), .m_axis_data_tready(m_ready[1]), .m_axis_data_tdata(m_data[1]),
    .m_axis_data_tlast(m_last[1]), .frame_count(fc_b), .busy(busy[1]));

  util_axis_framer #(.DATA_WIDTH(DW), .FRAME_LEN(1), .GAP_CYCLES(0), .CNT_WIDTH(2)) u_c (
    .aclk(aclk), .rst_n(rst_n), .enable(enable[2]),
    .s_axis_data_tvalid(s_valid[2]), .s_axis_data_tready(s_ready[2]), .s_axis_data_tdata(s_data[2]),
    .m_axis_data_tvalid(m_valid[2]), .m_axis_data_tready(m_ready[2]), .m_axis_data_tdata(m_data[2]),
    .m_axis_data_tlast(m_last[2]), .frame_count(fc_c), .busy(busy[2]));

  // Reference model: accepted beats in order, framed purely by output index.
  int unsigned   src_next [3];
  int unsigned   expq     [3][$];
  int            out_idx  [3];
  int            exp_fc   [3];
  int            last_acc [3];
  int            last_out [3];
  int            ph       [3];
  bit            v_hold   [3];
  bit            hold_pend[3];
  logic [DW-1:0] hold_data[3];
  logic          hold_last[3];
  int n_vec = 0;
  int n_err = 0;

  function automatic int flen(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int fcmod(input int k);
    return (k == 2) ? 4 : 65536;
  endfunction

  function automatic int get_fc(input int k);
    case (k)
      0:       return int'(fc_a);
      1:       return int'(fc_b);
      default: return int'(fc_c);
    endcase
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      enable[k] = 1'b0; s_valid[k] = 1'b0; m_ready[k] = 1'b0; s_data[k] = '0;
      src_next[k] = 0; expq[k].delete(); out_idx[k] = 0; exp_fc[k] = 0;
      last_acc[k] = -1; last_out[k] = -1; ph[k] = 0;
      v_hold[k] = 1'b0; hold_pend[k] = 1'b0; hold_data[k] = '0; hold_last[k] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    #2 rst_n = 1'b0;
    clear_model();
    @(negedge aclk);
    #3 rst_n = 1'b1;
  endtask

  // One clock of source/sink activity on framer k; rp < 0 selects 1-of-3 ready.
  task automatic cycle(input int k, input int vp, input int rp);
    logic [DW-1:0] exp_d;
    logic          exp_l;
    @(negedge aclk);
    if (!v_hold[k]) s_valid[k] = ($urandom_range(0, 99) < vp);
    s_data[k] = src_next[k];
    if (rp < 0) m_ready[k] = (ph[k] % 3 == 0);
    else        m_ready[k] = ($urandom_range(0, 99) < rp);
    ph[k]++;
    #1;
    n_vec++;
    if (get_fc(k) !== exp_fc[k] % fcmod(k)) begin
      n_err++;
      $display("FAIL frame_count[%0d]: got %0d want %0d", k, get_fc(k), exp_fc[k] % fcmod(k));
    end
    if (hold_pend[k]) begin
      n_vec++;
      if (m_valid[k] !== 1'b1 || m_data[k] !== hold_data[k] || m_last[k] !== hold_last[k]) begin
        n_err++;
        $display("FAIL stable[%0d]: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                 k, m_valid[k], m_data[k], m_last[k], hold_data[k], hold_last[k]);
      end
    end
    last_acc[k] = -1;
    last_out[k] = -1;
    if (s_valid[k] && s_ready[k]) begin
      expq[k].push_back(src_next[k]);
      last_acc[k] = int'(src_next[k]);
      src_next[k]++;
    end
    v_hold[k] = s_valid[k] && !s_ready[k];
    if (m_valid[k] && m_ready[k]) begin
      n_vec++;
      if (expq[k].size() == 0) begin
        n_err++;
        $display("FAIL extra_beat[%0d]: got d=%0d want no beat", k, m_data[k]);
      end else begin
        exp_d = expq[k].pop_front();
        exp_l = (out_idx[k] % flen(k)) == (flen(k) - 1);
        if (m_data[k] !== exp_d || m_last[k] !== exp_l) begin
          n_err++;
          $display("FAIL beat[%0d] #%0d: got d=%0d l=%b want d=%0d l=%b",
                   k, out_idx[k], m_data[k], m_last[k], exp_d, exp_l);
        end
        if (exp_l) exp_fc[k]++;
      end
      last_out[k] = int'(m_data[k]);
      out_idx[k]++;
    end
    hold_pend[k] = m_valid[k] && !m_ready[k];
    hold_data[k] = m_data[k];
    hold_last[k] = m_last[k];
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (m_valid[k] !== 1'b0 || s_ready[k] !== 1'b0 || busy[k] !== 1'b0 ||
          m_last[k] !== 1'b0 || m_data[k] !== '0 || get_fc(k) !== 0) begin
        n_err++;
        $display("FAIL reset[%0d]: got v=%b r=%b busy=%b l=%b d=%0d fc=%0d want all 0",
                 k, m_valid[k], s_ready[k], busy[k], m_last[k], m_data[k], get_fc(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    int bubbles = 0;
    int n = 0;
    apply_reset();
    enable[0] = 1'b1;
    while (out_idx[0] < 12 && n < 100) begin
      cycle(0, 100, 100);
      if (out_idx[0] > 0 && out_idx[0] < 12 && m_valid[0] !== 1'b1) bubbles++;
      n++;
    end
    n_vec++;
    if (out_idx[0] != 12 || bubbles != 0) begin
      n_err++;
      $display("FAIL b2b: got beats=%0d bubbles=%0d want beats=12 bubbles=0", out_idx[0], bubbles);
    end
    cycle(0, 100, 100);
    n_vec++;
    if (fc_a !== 16'd3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d want 3", fc_a);
    end
  endtask

  task automatic test_gap();
    bit seen = 1'b0;
    bit done = 1'b0;
    int low = 0;
    int n = 0;
    apply_reset();
    enable[1] = 1'b1;
    while (!(done && out_idx[1] >= 8) && n < 200) begin
      cycle(1, 100, 100);
      if (seen && !done) begin
        if (s_ready[1] === 1'b0) low++;
        else done = 1'b1;
      end
      if (last_acc[1] == 3) seen = 1'b1;
      n++;
    end
    n_vec++;
    if (low != 2 || out_idx[1] < 8) begin
      n_err++;
      $display("FAIL gap: got low_cycles=%0d beats=%0d want low_cycles=2 beats>=8", low, out_idx[1]);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    apply_reset();
    enable[0] = 1'b1;
    while (out_idx[0] < 1024 && n < 8000) begin
      cycle(0, 70, -1);
      n++;
    end
    n_vec++;
    if (out_idx[0] != 1024 || last_out[0] != 1023) begin
      n_err++;
      $display("FAIL backpressure: got beats=%0d last=%0d want beats=1024 last=1023",
               out_idx[0], last_out[0]);
    end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    apply_reset();
    enable[0] = 1'b1;
    while (src_next[0] < 6 && n < 100) begin
      cycle(0, 100, 100);
      n++;
    end
    enable[0] = 1'b0;
    for (int i = 0; i < 20; i++) cycle(0, 100, 100);
    n_vec++;
    if (out_idx[0] != 8 || src_next[0] != 8 || s_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL enable_drop: got beats=%0d accepted=%0d r=%b busy=%b want 8 8 0 0",
               out_idx[0], src_next[0], s_ready[0], busy[0]);
    end
    enable[0] = 1'b1;
    n = 0;
    while (out_idx[0] < 9 && n < 100) begin
      cycle(0, 100, 100);
      n++;
    end
    n_vec++;
    if (last_out[0] != 8) begin
      n_err++;
      $display("FAIL resume: got %0d want 8", last_out[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int first_last = -1;
    apply_reset();
    enable[0] = 1'b1;
    while (out_idx[0] < 6 && n < 100) begin
      cycle(0, 100, 100);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (m_valid[0] !== 1'b0 || s_ready[0] !== 1'b0 || fc_a !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b r=%b fc=%0d want 0 0 0", m_valid[0], s_ready[0], fc_a);
    end
    clear_model();
    #3 rst_n = 1'b1;
    enable[0] = 1'b1;
    n = 0;
    while (out_idx[0] < 4 && n < 100) begin
      cycle(0, 100, 100);
      if (last_out[0] >= 0 && m_last[0] === 1'b1 && first_last < 0) first_last = out_idx[0];
      n++;
    end
    n_vec++;
    if (first_last != 4) begin
      n_err++;
      $display("FAIL reset_first_frame: got tlast on beat %0d want 4", first_last);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    apply_reset();
    enable[2] = 1'b1;
    while (out_idx[2] < 5 && n < 100) begin
      cycle(2, 100, 100);
      n++;
    end
    enable[2] = 1'b0;
    cycle(2, 100, 0);
    n_vec++;
    if (out_idx[2] != 5 || fc_c !== 2'd1) begin
      n_err++;
      $display("FAIL wrap: got beats=%0d fc=%0d want beats=5 fc=1", out_idx[2], fc_c);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_back_to_back();
    test_gap();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
